// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_pkg
//  Brief    : Shared CPU datapath widths and types. The register file, ALU
//             and data memory all use these.
//  Revision : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : data_memory_pkg
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory
//  Brief    : 256 x 8 byte-addressable data memory with a single shared port.
//             Writes are synchronous, reads are combinational, and an
//             asynchronous active-low reset clears the whole array.
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory
  import data_memory_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEn,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataInput,
  output logic [DATA_WIDTH-1:0] dataOutput
);

  data_t mem_q [DEPTH];
  data_t mem_d [DEPTH];

  // Next-state image: only the addressed word changes, and only when enabled.
  always_comb begin
    mem_d = mem_q;
    if (writeEn) begin
      mem_d[address] = dataInput;
    end
  end

  // Storage array; reset is held for as long as it is low, so writes lose to it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read: a write is visible as soon as the edge updates mem_q.
  assign dataOutput = mem_q[address];

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory
//  Brief    : Self-checking bench for data_memory. It uses directed sequences,
//             a vector table, and randomized traffic compared against an
//             array-based model of the memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  logic       clk;
  logic       reset;
  logic       writeEn;
  logic [7:0] address;
  logic [7:0] dataInput;
  logic [7:0] dataOutput;

  int n_checks;
  int n_fail;

  // Reference image of the memory: plain array, cleared on reset, written on enable.
  logic [7:0] model [256];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] exp;   // dataOutput expected after the clock edge
  } vec_t;

  vec_t vecs [8];

  data_memory dut (
    .clk        (clk),
    .reset      (reset),
    .writeEn    (writeEn),
    .address    (address),
    .dataInput  (dataInput),
    .dataOutput (dataOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  // One write cycle; inputs change 1 time unit after a rising edge.
  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    address   = a;
    dataInput = d;
    writeEn   = 1'b1;
    @(posedge clk);
    #1;
    writeEn   = 1'b0;
    model[a]  = d;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any rising edge.
  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_immediate", dataOutput, 8'h00);
    #1;
    reset = 1'b1;
    clear_model();
    #1;
  endtask

  task automatic sweep_zero(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      address = 8'(i);
      #1;
      if (dataOutput !== 8'h00) begin
        bad++;
        if (bad <= 4) begin
          $display("FAIL %s: addr 0x%02h got 0x%02h, expected 0x00", name, i[7:0], dataOutput);
        end
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    writeEn   = 1'b0;
    address   = 8'h00;
    dataInput = 8'h00;
    clear_model();

    // ---------------- Reset clear ----------------
    @(posedge clk);
    #1;
    check("reset_state", dataOutput, 8'h00);
    reset = 1'b1;
    sweep_zero("reset_sweep");

    // ---------------- Write/readback sweep ----------------
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        write_byte(8'(i), 8'(i));
        if (dataOutput !== 8'(i)) begin
          bad++;
          if (bad <= 4) begin
            $display("FAIL wr_sweep: addr 0x%02h got 0x%02h, expected 0x%02h", i[7:0], dataOutput, i[7:0]);
          end
        end
      end
      n_checks++;
      if (bad != 0) n_fail++;
      // Second pass without writes: all data must still be there.
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        address = 8'(i);
        #1;
        if (dataOutput !== 8'(i)) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL rd_sweep: %0d locations wrong, expected 0", bad);
      end
    end

    // ---------------- Write-enable gating ----------------
    @(posedge clk);
    #1;
    address   = 8'h10;
    dataInput = 8'hAA;
    writeEn   = 1'b0;
    @(posedge clk);
    #1;
    check("we_gating", dataOutput, 8'h10);
    address = 8'hFF;
    #1;
    check("addr_ff_after_fill", dataOutput, 8'hFF);

    // ---------------- Async reset after fill ----------------
    @(posedge clk);
    #1;
    address = 8'h10;
    pulse_reset();
    sweep_zero("post_reset_sweep");

    // ---------------- Reset priority over writeEn ----------------
    @(posedge clk);
    #1;
    reset     = 1'b0;
    writeEn   = 1'b1;
    address   = 8'h42;
    dataInput = 8'h5A;
    @(posedge clk);
    #1;
    writeEn = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("reset_priority", dataOutput, 8'h00);
    // Writes resume on the first edge after release.
    write_byte(8'h42, 8'h5A);
    check("write_after_release", dataOutput, 8'h5A);

    // ---------------- Combinational read ----------------
    write_byte(8'h01, 8'h33);
    write_byte(8'hFE, 8'hCC);
    #1;
    address = 8'h01; #1; check("comb_rd_01_a", dataOutput, 8'h33);
    address = 8'hFE; #1; check("comb_rd_fe_a", dataOutput, 8'hCC);
    address = 8'h01; #1; check("comb_rd_01_b", dataOutput, 8'h33);
    address = 8'hFE; #1; check("comb_rd_fe_b", dataOutput, 8'hCC);

    // ---------------- Table-driven vectors (from a cleared memory) ----------------
    @(posedge clk);
    #1;
    pulse_reset();
    vecs[0] = '{we: 1'b1, addr: 8'hFF, din: 8'hA5, exp: 8'hA5};
    vecs[1] = '{we: 1'b0, addr: 8'hFF, din: 8'h00, exp: 8'hA5};
    vecs[2] = '{we: 1'b1, addr: 8'h00, din: 8'h7E, exp: 8'h7E};
    vecs[3] = '{we: 1'b0, addr: 8'hFF, din: 8'h11, exp: 8'hA5};
    vecs[4] = '{we: 1'b1, addr: 8'h80, din: 8'h80, exp: 8'h80};
    vecs[5] = '{we: 1'b0, addr: 8'h80, din: 8'hFF, exp: 8'h80};
    vecs[6] = '{we: 1'b1, addr: 8'hFF, din: 8'h3C, exp: 8'h3C};
    vecs[7] = '{we: 1'b0, addr: 8'h7F, din: 8'h99, exp: 8'h00};
    for (int i = 0; i < 8; i++) begin
      address   = vecs[i].addr;
      dataInput = vecs[i].din;
      writeEn   = vecs[i].we;
      @(posedge clk);
      #1;
      writeEn = 1'b0;
      check($sformatf("vec%0d", i), dataOutput, vecs[i].exp);
      if (vecs[i].we) model[vecs[i].addr] = vecs[i].din;
    end
    address = 8'h00; #1; check("vec_addr00_kept", dataOutput, 8'h7E);

    // ---------------- Randomized traffic vs model ----------------
    for (int n = 0; n < 1500; n++) begin
      logic       we;
      logic [7:0] a;
      logic [7:0] d;
      we = ($urandom_range(0, 2) != 0);
      // Bias toward a small address window so reads hit written data often.
      a  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      d  = 8'($urandom);
      address   = a;
      dataInput = d;
      writeEn   = we;
      #1;
      check("rand_pre_edge", dataOutput, model[a]);
      @(posedge clk);
      #1;
      writeEn = 1'b0;
      if (we) model[a] = d;
      check("rand_post_edge", dataOutput, model[a]);
      address = 8'($urandom_range(0, 15));
      #1;
      check("rand_probe", dataOutput, model[address]);
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_memory
`default_nettype wire
